// File: rtl/yadmc_arb_pkg.sv
// Shared constants for the YADMC buffer-RAM port arbiter: requester count, pointer width, state codes.
// No logic; no latency; no backpressure.
// Imported by yadmc_rr_pick and yadmc_dpram_arb.
package yadmc_arb_pkg;
    localparam int NREQ  = 4;
    localparam int PTR_W = 2;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
endpackage

// File: rtl/yadmc_rr_pick.sv
// Round-robin picker: first asserted req scanning from ptr upward (mod NREQ).
// Latency: purely combinational.
// Backpressure: none; losers simply see no grant this cycle.
module yadmc_rr_pick
    import yadmc_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [PTR_W-1:0] win,
    output logic             vld
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt = '0;
        win = '0;
        vld = 1'b0;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr + PTR_W'(i);
            if (!vld && req[idx]) begin
                vld      = 1'b1;
                win      = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/yadmc_dpram_arb.sv
// Four-requester round-robin arbiter for one YADMC buffer-RAM port, with optional zeroing sweep (YADMC_ARB_CLEAR_EN).
// Latency: grant and RAM drive same cycle; rvalid one cycle after a read grant.
// Backpressure: requesters hold their access until ack; all acks withheld while the sweep runs.
module yadmc_dpram_arb
    import yadmc_arb_pkg::*;
#(
    parameter int address_depth = 10,
    parameter int data_width    = 8
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    input  logic [NREQ-1:0]                 req,
    input  logic [NREQ-1:0]                 we,
    input  logic [NREQ*address_depth-1:0]   adr,
    input  logic [NREQ*data_width-1:0]      di,
    output logic [NREQ-1:0]                 ack,
    output logic [NREQ-1:0]                 rvalid,
    output logic [data_width-1:0]           dout,
    output logic                            ready,
    input  logic                            clr,
    output logic [address_depth-1:0]        ram_adr,
    output logic                            ram_we,
    output logic [data_width-1:0]           ram_di,
    input  logic [data_width-1:0]           ram_do
);

    logic [PTR_W-1:0]         ptr;
    logic [PTR_W-1:0]         win;
    logic [NREQ-1:0]          gnt;
    logic                     vld;
    logic                     run;
    logic [address_depth-1:0] cnt;

    yadmc_rr_pick u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (gnt),
        .win (win),
        .vld (vld)
    );

`ifdef YADMC_ARB_CLEAR_EN
    logic [0:0] state;

    // Sweep ends after writing the all-ones address; the counter wraps back to 0 on its own.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else if (state == ST_CLEAR) begin
            cnt <= cnt + 1'b1;
            if (&cnt)
                state <= ST_RUN;
        end else if (clr) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end
    end

    assign run = (state == ST_RUN);
`else
    logic unused_clr;

    assign unused_clr = clr;
    assign run        = 1'b1;
    assign cnt        = '0;
`endif

    assign ready   = run;
    assign ack     = run ? gnt : '0;
    assign ram_we  = run ? (vld & we[win]) : 1'b1;
    assign ram_adr = run ? adr[int'(win)*address_depth +: address_depth] : cnt;
    assign ram_di  = run ? di[int'(win)*data_width +: data_width] : '0;
    assign dout    = ram_do;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ptr    <= '0;
            rvalid <= '0;
        end else begin
            if (run && vld)
                ptr <= win + PTR_W'(1);
            // A read granted before clr still returns: rvalid only depends on last cycle's grant.
            rvalid <= (run && vld && !we[win]) ? gnt : '0;
        end
    end

endmodule

// File: tb/tb_yadmc_dpram_arb.sv
// Directed bench for yadmc_dpram_arb with a registered-output RAM model on the port.
// Covers both builds; sweep and clr steps are present only with YADMC_ARB_CLEAR_EN.
module tb_yadmc_dpram_arb;
    localparam int AW = 10;
    localparam int DW = 8;

    logic            sys_clk;
    logic            sys_rst;
    logic [3:0]      req;
    logic [3:0]      we;
    logic [4*AW-1:0] adr;
    logic [4*DW-1:0] di;
    logic [3:0]      ack;
    logic [3:0]      rvalid;
    logic [DW-1:0]   dout;
    logic            ready;
    logic            clr;
    logic [AW-1:0]   ram_adr;
    logic            ram_we;
    logic [DW-1:0]   ram_di;
    logic [DW-1:0]   ram_do;

    logic [DW-1:0]   mem [0:(1<<AW)-1];

    int nvec;
    int nerr;

`ifdef YADMC_ARB_CLEAR_EN
    localparam logic RST_READY = 1'b0;
    localparam logic RST_WE    = 1'b1;
`else
    localparam logic RST_READY = 1'b1;
    localparam logic RST_WE    = 1'b0;
`endif

    yadmc_dpram_arb #(.address_depth(AW), .data_width(DW)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .req     (req),
        .we      (we),
        .adr     (adr),
        .di      (di),
        .ack     (ack),
        .rvalid  (rvalid),
        .dout    (dout),
        .ready   (ready),
        .clr     (clr),
        .ram_adr (ram_adr),
        .ram_we  (ram_we),
        .ram_di  (ram_di),
        .ram_do  (ram_do)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (ram_we)
            mem[ram_adr] <= ram_di;
        ram_do <= mem[ram_adr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] e;
        logic       bad;
        nvec = 0;
        nerr = 0;
        req = '0; we = '0; adr = '0; di = '0; clr = 1'b0; sys_rst = 1'b1;
        for (int i = 0; i < 4; i++)
            adr[i*AW +: AW] = AW'(16 + i);

        @(negedge sys_clk); #1;
        chk("rst_state", {ack, rvalid, ready, ram_we}, {4'b0000, 4'b0000, RST_READY, RST_WE});
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;

`ifdef YADMC_ARB_CLEAR_EN
        for (int c = 0; c < 1024; c++) begin
            if (c > 0) begin
                @(negedge sys_clk); #1;
            end
            chk("sweep", {ready, ack, ram_we, ram_di, ram_adr}, {1'b0, 4'b0000, 1'b1, 8'h00, 10'(c)});
        end
        @(negedge sys_clk); #1;
        chk("ready_after_sweep", {28'd0, ready}, 1);
        for (int a = 0; a < 1024; a++) begin
            @(negedge sys_clk);
            req = 4'b0001; we = '0; adr[0 +: AW] = AW'(a);
            #1;
            chk("zero_rd_ack", {60'd0, ack}, 64'h1);
            if (a > 0)
                chk("zero_rd_data", {rvalid, dout}, {4'b0001, 8'h00});
        end
        @(negedge sys_clk);
        req = '0;
        #1;
        chk("zero_rd_last", {rvalid, dout}, {4'b0001, 8'h00});
`endif

        // Requester 3 alone moves ptr to 0 whatever it was before.
        @(negedge sys_clk);
        req = 4'b1000; we = '0; adr[3*AW +: AW] = 10'h013;
        #1;
        chk("prime_ack", {60'd0, ack}, 64'h8);

        for (int k = 0; k < 6; k++) begin
            @(negedge sys_clk);
            req = 4'b1111; we = '0;
            #1;
            e = 4'b0001 << (k % 4);
            chk("rr_ack", {ack, ram_we, ram_adr}, {e, 1'b0, 10'(16 + k % 4)});
            e = (k == 0) ? 4'b1000 : (4'b0001 << ((k - 1) % 4));
            chk("rr_rvalid", {60'd0, rvalid}, {60'd0, e});
        end
        @(negedge sys_clk);
        req = '0;
        #1;
        chk("rr_rvalid_last", {ack, rvalid}, {4'b0000, 4'b0010});

        @(negedge sys_clk);
        req = 4'b0100; we = 4'b0100; adr[2*AW +: AW] = 10'h123; di[2*DW +: DW] = 8'h5A;
        #1;
        chk("wr_drive", {ack, ram_we, ram_adr, ram_di}, {4'b0100, 1'b1, 10'h123, 8'h5A});
        @(negedge sys_clk);
        we = '0;
        #1;
        chk("rd_drive", {ack, ram_we, ram_adr}, {4'b0100, 1'b0, 10'h123});
        chk("wr_no_rvalid", {60'd0, rvalid}, 64'h0);
        @(negedge sys_clk);
        req = '0;
        #1;
        chk("rd_data", {ack, rvalid, dout}, {4'b0000, 4'b0100, 8'h5A});

        @(negedge sys_clk);
        req = 4'b1001;
        #1;
        chk("wrap_ack3", {60'd0, ack}, 64'h8);
        @(negedge sys_clk);
        req = 4'b0001;
        #1;
        chk("wrap_ack0", {ack, rvalid}, {4'b0001, 4'b1000});
        @(negedge sys_clk);
        req = 4'b1111;
        #1;
        chk("ptr_is_1", {ack, rvalid}, {4'b0010, 4'b0001});
        @(negedge sys_clk);
        req = '0;
        #1;
        chk("ptr_is_1_rv", {60'd0, rvalid}, 64'h2);

        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            req = 4'b0010; we = 4'b0010; adr[AW +: AW] = AW'(10'h200 + k); di[DW +: DW] = DW'(8'hC0 + k);
            #1;
            chk("b2b_wr", {ack, ram_we, ram_adr, ram_di}, {4'b0010, 1'b1, 10'(10'h200 + k), 8'(8'hC0 + k)});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            req = 4'b0010; we = '0; adr[AW +: AW] = AW'(10'h200 + k);
            #1;
            chk("b2b_rd_ack", {60'd0, ack}, 64'h2);
            if (k > 0)
                chk("b2b_rd_data", {rvalid, dout}, {4'b0010, 8'(8'hC0 + k - 1)});
        end
        @(negedge sys_clk);
        req = '0;
        #1;
        chk("b2b_rd_last", {rvalid, dout}, {4'b0010, 8'hC2});

`ifdef YADMC_ARB_CLEAR_EN
        @(negedge sys_clk);
        req = 4'b0010; we = '0; adr[AW +: AW] = 10'h123; clr = 1'b1;
        #1;
        chk("clr_rd_ack", {ack, ready}, {4'b0010, 1'b1});
        @(negedge sys_clk);
        clr = 1'b0;
        #1;
        chk("clr_rvalid_kept", {rvalid, dout}, {4'b0010, 8'h5A});
        chk("clr_enter", {ready, ack, ram_we, ram_adr}, {1'b0, 4'b0000, 1'b1, 10'h000});
        bad = 1'b0;
        for (int n = 1; n < 1024; n++) begin
            @(negedge sys_clk); #1;
            if (ack !== 4'b0000 || ready !== 1'b0 || ram_adr !== AW'(n) || rvalid !== 4'b0000)
                bad = 1'b1;
        end
        chk("clr_held_off", {63'd0, bad}, 64'h0);
        @(negedge sys_clk); #1;
        chk("clr_release", {ready, ack}, {1'b1, 4'b0010});
        @(negedge sys_clk);
        req = '0;
        #1;
        chk("clr_zeroed", {rvalid, dout}, {4'b0010, 8'h00});

        @(negedge sys_clk);
        clr = 1'b1;
        @(negedge sys_clk);
        clr = 1'b0;
        repeat (500) @(negedge sys_clk);
        #1;
        chk("sweep_500", {ready, ram_adr}, {1'b0, 10'd500});
        sys_rst = 1'b1;
        #1;
        chk("rst_mid_sweep", {ready, ram_we, ram_adr, rvalid}, {1'b0, 1'b1, 10'd0, 4'b0000});
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        chk("restart_0", {ram_we, ram_adr}, {1'b1, 10'd0});
        @(negedge sys_clk); #1;
        chk("restart_1", {ram_we, ram_adr}, {1'b1, 10'd1});
        @(negedge sys_clk); #1;
        chk("restart_2", {ram_adr, rvalid}, {10'd2, 4'b0000});
        repeat (1022) @(negedge sys_clk);
        #1;
        chk("restart_done", {28'd0, ready}, 1);
`endif

        @(negedge sys_clk);
        req = 4'b0001; we = '0; adr[0 +: AW] = 10'h123;
        #1;
        chk("pre_rst_ack", {60'd0, ack}, 64'h1);
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        req = '0;
        @(negedge sys_clk); #1;
        chk("rst_drops_rvalid", {rvalid, ready, ram_we}, {4'b0000, RST_READY, RST_WE});
        @(negedge sys_clk);
        sys_rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
